// File: rtl/tl_ul_pkg.sv
// TileLink-UL opcode encodings and the D-channel response record shared by
// the MMIO responder and its register bank.
package tl_ul_pkg;

  // The response record carries a fixed-width source field. The top level
  // zero-extends its SRC_W-bit source into this field and truncates it back
  // on output, so SRC_W must not exceed this width.
  localparam int unsigned TL_SRC_W_MAX = 16;

  typedef enum logic [2:0] {
    PutFull    = 3'd0,
    PutPartial = 3'd1,
    Arith      = 3'd2,
    Logical    = 3'd3,
    Get        = 3'd4,
    Intent     = 3'd5
  } tl_a_op_e;

  typedef enum logic [2:0] {
    AccessAck     = 3'd0,
    AccessAckData = 3'd1
  } tl_d_op_e;

  typedef struct packed {
    tl_d_op_e                opcode;
    logic [2:0]              size;
    logic [TL_SRC_W_MAX-1:0] source;
    logic                    denied;
    logic [63:0]             data;
  } tl_d_resp_t;

endpackage

// File: rtl/mmio_tl_responder_if.sv
// TileLink-UL A/D channel bundle between the IO MSHR (master) and the MMIO
// responder (slave).
interface mmio_tl_responder_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned SRC_W  = 4
);

  logic              a_valid;
  logic              a_ready;
  logic [2:0]        a_opcode;
  logic [2:0]        a_param;
  logic [2:0]        a_size;
  logic [SRC_W-1:0]  a_source;
  logic [ADDR_W-1:0] a_address;
  logic [7:0]        a_mask;
  logic [63:0]       a_data;

  logic              d_valid;
  logic              d_ready;
  logic [2:0]        d_opcode;
  logic [2:0]        d_size;
  logic [SRC_W-1:0]  d_source;
  logic              d_denied;
  logic [63:0]       d_data;

  modport master (
    output a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data,
    output d_ready,
    input  a_ready,
    input  d_valid, d_opcode, d_size, d_source, d_denied, d_data
  );

  modport slave (
    input  a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data,
    input  d_ready,
    output a_ready,
    output d_valid, d_opcode, d_size, d_source, d_denied, d_data
  );

endinterface

// File: rtl/mmio_tl_regfile.sv
// Bank of NUM_REGS 64-bit registers with byte-masked write and an
// asynchronous read port that returns the pre-write value.
module mmio_tl_regfile #(
  parameter int unsigned NUM_REGS = 8,
  parameter int unsigned IDX_W    = 3
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  we,
  input  logic [IDX_W-1:0]      widx,
  input  logic [7:0]            wmask,
  input  logic [63:0]           wdata,
  input  logic [IDX_W-1:0]      ridx,
  output logic [63:0]           rdata,
  output logic [NUM_REGS*64-1:0] regs_q
);

  logic [63:0] regs [NUM_REGS];

  // Clear on reset; otherwise update only the enabled byte lanes.
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (we) begin
      for (int unsigned b = 0; b < 8; b++) begin
        if (wmask[b]) begin
          regs[widx][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

  assign rdata = regs[ridx];

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign regs_q[64*g +: 64] = regs[g];
  end

endmodule

// File: rtl/mmio_tl_responder.sv
// TileLink-UL MMIO responder: accepts one A-channel request at a time,
// decodes it against a small register bank and returns the D response one
// cycle later, holding it until the requester takes it.
module mmio_tl_responder
  import tl_ul_pkg::*;
#(
  parameter int unsigned       ADDR_W    = 32,
  parameter int unsigned       SRC_W     = 4,
  parameter int unsigned       NUM_REGS  = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 'h6000_0000
) (
  input  logic                   clock,
  input  logic                   reset,
  mmio_tl_responder_if.slave     tl,
  output logic [NUM_REGS*64-1:0] regs_q
);

  localparam int unsigned       IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [ADDR_W-1:0] SPAN  = ADDR_W'(NUM_REGS * 8);

  typedef enum logic {
    IDLE,
    RESP
  } state_e;

  state_e            state_q, state_n;
  tl_d_resp_t        resp_q, resp_n;
  logic              a_fire, d_fire;
  logic              in_range, aligned, size_ok, ok, wr_en;
  logic [ADDR_W-1:0] off, align_mask;
  logic [IDX_W-1:0]  idx;
  logic [63:0]       rdata;
  logic              unused_bits;

  assign a_fire = tl.a_valid && (state_q == IDLE);
  assign d_fire = tl.d_ready && (state_q == RESP);

  // Unsigned compare against the base keeps addresses below it from wrapping
  // into the top register through the subtraction.
  assign off        = tl.a_address - BASE_ADDR;
  assign idx        = off[IDX_W+2:3];
  assign in_range   = (tl.a_address >= BASE_ADDR) && (off < SPAN);
  assign align_mask = (ADDR_W'(1) << tl.a_size) - ADDR_W'(1);
  assign aligned    = (tl.a_address & align_mask) == '0;
  assign size_ok    = tl.a_size <= 3'd3;
  assign ok         = in_range && aligned && size_ok;

  // Next-state: accept in IDLE, release on D handshake.
  always_comb begin
    state_n = state_q;
    case (state_q)
      IDLE:    if (tl.a_valid)  state_n = RESP;
      RESP:    if (tl.d_ready)  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Build the response for the request on channel A and gate the write.
  always_comb begin
    resp_n        = '0;
    resp_n.opcode = AccessAck;
    resp_n.size   = tl.a_size;
    resp_n.source = TL_SRC_W_MAX'(tl.a_source);
    resp_n.denied = 1'b1;
    resp_n.data   = '0;
    wr_en         = 1'b0;
    case (tl.a_opcode)
      PutFull, PutPartial: begin
        resp_n.denied = !ok;
        wr_en         = ok && a_fire;
      end
      Get: begin
        resp_n.opcode = AccessAckData;
        resp_n.denied = !ok;
        resp_n.data   = ok ? rdata : 64'd0;
      end
      Arith, Logical: begin
        resp_n.opcode = AccessAckData;
      end
      default: begin
        resp_n.opcode = AccessAck;
      end
    endcase
  end

  // State register and response hold; the response only changes on A fire.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
      resp_q  <= '0;
    end else begin
      state_q <= state_n;
      if (a_fire) begin
        resp_q <= resp_n;
      end
    end
  end

  mmio_tl_regfile #(
    .NUM_REGS (NUM_REGS),
    .IDX_W    (IDX_W)
  ) u_regfile (
    .clock  (clock),
    .reset  (reset),
    .we     (wr_en),
    .widx   (idx),
    .wmask  (tl.a_mask),
    .wdata  (tl.a_data),
    .ridx   (idx),
    .rdata  (rdata),
    .regs_q (regs_q)
  );

  assign tl.a_ready  = (state_q == IDLE);
  assign tl.d_valid  = (state_q == RESP);
  assign tl.d_opcode = resp_q.opcode;
  assign tl.d_size   = resp_q.size;
  assign tl.d_source = resp_q.source[SRC_W-1:0];
  assign tl.d_denied = resp_q.denied;
  assign tl.d_data   = resp_q.data;

  assign unused_bits = ^{tl.a_param, off, resp_q.source, d_fire};

endmodule

// File: tb/tb_mmio_tl_responder.sv
// Bench for mmio_tl_responder: vector table through a scoreboard plus
// directed backpressure and reset-during-response sequences.
module tb_mmio_tl_responder;

  localparam int unsigned NUM_REGS = 8;
  localparam logic [31:0] BASE     = 32'h6000_0000;

  logic                    clock;
  logic                    reset;
  logic [NUM_REGS*64-1:0]  regs_q;

  mmio_tl_responder_if #(.ADDR_W(32), .SRC_W(4)) tl ();

  mmio_tl_responder #(
    .ADDR_W    (32),
    .SRC_W     (4),
    .NUM_REGS  (NUM_REGS),
    .BASE_ADDR (BASE)
  ) dut (
    .clock  (clock),
    .reset  (reset),
    .tl     (tl),
    .regs_q (regs_q)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [2:0]  op;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [7:0]  mask;
    logic [63:0] data;
    logic [3:0]  src;
    logic [2:0]  exp_op;
    logic        exp_den;
    logic [63:0] exp_data;
  } vec_t;

  typedef struct {
    logic [2:0]  op;
    logic [2:0]  size;
    logic [3:0]  src;
    logic        den;
    logic [63:0] data;
  } exp_t;

  localparam int NV = 17;
  vec_t        vecs [NV];
  exp_t        sb [$];
  logic [63:0] model [NUM_REGS];
  int          checks = 0;
  int          errors = 0;

  function automatic vec_t mk(input logic [2:0] op, input logic [2:0] size,
                              input logic [31:0] addr, input logic [7:0] mask,
                              input logic [63:0] data, input logic [3:0] src,
                              input logic [2:0] exp_op, input logic exp_den,
                              input logic [63:0] exp_data);
    vec_t v;
    v.op = op; v.size = size; v.addr = addr; v.mask = mask; v.data = data;
    v.src = src; v.exp_op = exp_op; v.exp_den = exp_den; v.exp_data = exp_data;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_regs(input string name);
    for (int i = 0; i < NUM_REGS; i++) begin
      chk($sformatf("%s_reg%0d", name, i), regs_q[64*i +: 64], model[i]);
    end
  endtask

  task automatic pop_compare(input string name);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s_sb_empty: got d_valid with no expected response", name);
    end else begin
      errors--;
      checks--;
      e = sb.pop_front();
      chk({name, "_opcode"}, 64'(tl.d_opcode), 64'(e.op));
      chk({name, "_size"},   64'(tl.d_size),   64'(e.size));
      chk({name, "_source"}, 64'(tl.d_source), 64'(e.src));
      chk({name, "_denied"}, 64'(tl.d_denied), 64'(e.den));
      chk({name, "_data"},   tl.d_data,        e.data);
      errors++;
    end
  endtask

  // Drive one request; response is compared the cycle after fire.
  task automatic drive_req(input vec_t v, input string name);
    exp_t e;
    int   idx;
    @(negedge clock);
    tl.a_valid   = 1'b1;
    tl.a_opcode  = v.op;
    tl.a_param   = 3'd0;
    tl.a_size    = v.size;
    tl.a_source  = v.src;
    tl.a_address = v.addr;
    tl.a_mask    = v.mask;
    tl.a_data    = v.data;
    chk({name, "_a_ready_at_fire"}, 64'(tl.a_ready), 64'd1);
    e.op = v.exp_op; e.size = v.size; e.src = v.src; e.den = v.exp_den; e.data = v.exp_data;
    sb.push_back(e);
    if (!v.exp_den && (v.op == 3'd0 || v.op == 3'd1)) begin
      idx = int'((v.addr - BASE) >> 3);
      for (int b = 0; b < 8; b++) begin
        if (v.mask[b]) model[idx][8*b +: 8] = v.data[8*b +: 8];
      end
    end
    @(negedge clock);
    tl.a_valid = 1'b0;
    chk({name, "_d_valid_latency"}, 64'(tl.d_valid), 64'd1);
    chk({name, "_a_ready_in_resp"}, 64'(tl.a_ready), 64'd0);
    pop_compare(name);
  endtask

  task automatic send(input vec_t v, input string name);
    drive_req(v, name);
    @(negedge clock);
    chk({name, "_d_valid_after_fire"}, 64'(tl.d_valid), 64'd0);
    chk({name, "_a_ready_after_fire"}, 64'(tl.a_ready), 64'd1);
    chk_regs(name);
  endtask

  initial begin
    logic [63:0] held_data;
    logic [2:0]  held_op;
    logic [3:0]  held_src;
    logic        held_den;

    vecs[0]  = mk(3'd0, 3'd3, 32'h6000_0008, 8'hFF, 64'h1122334455667788, 4'd3, 3'd0, 1'b0, 64'h0);
    vecs[1]  = mk(3'd1, 3'd0, 32'h6000_0008, 8'h01, 64'h00000000000000AA, 4'd5, 3'd0, 1'b0, 64'h0);
    vecs[2]  = mk(3'd4, 3'd3, 32'h6000_0008, 8'hFF, 64'h0, 4'd6, 3'd1, 1'b0, 64'h11223344556677AA);
    vecs[3]  = mk(3'd4, 3'd3, 32'h6000_0040, 8'hFF, 64'h0, 4'd7, 3'd1, 1'b1, 64'h0);
    vecs[4]  = mk(3'd4, 3'd3, 32'h5FFF_FFF8, 8'hFF, 64'h0, 4'd8, 3'd1, 1'b1, 64'h0);
    vecs[5]  = mk(3'd4, 3'd2, 32'h6000_0002, 8'h0F, 64'h0, 4'd9, 3'd1, 1'b1, 64'h0);
    vecs[6]  = mk(3'd2, 3'd3, 32'h6000_0000, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, 4'd10, 3'd1, 1'b1, 64'h0);
    vecs[7]  = mk(3'd0, 3'd3, 32'h6000_0038, 8'hFF, 64'hDEADBEEFCAFEF00D, 4'd11, 3'd0, 1'b0, 64'h0);
    vecs[8]  = mk(3'd4, 3'd3, 32'h6000_0038, 8'hFF, 64'h0, 4'd12, 3'd1, 1'b0, 64'hDEADBEEFCAFEF00D);
    vecs[9]  = mk(3'd1, 3'd1, 32'h6000_0038, 8'h0C, 64'h0000000012340000, 4'd13, 3'd0, 1'b0, 64'h0);
    vecs[10] = mk(3'd4, 3'd3, 32'h6000_0038, 8'hFF, 64'h0, 4'd14, 3'd1, 1'b0, 64'hDEADBEEF1234F00D);
    vecs[11] = mk(3'd5, 3'd3, 32'h6000_0000, 8'hFF, 64'h5555, 4'd15, 3'd0, 1'b1, 64'h0);
    vecs[12] = mk(3'd0, 3'd3, 32'h6000_0040, 8'hFF, 64'h7777, 4'd1, 3'd0, 1'b1, 64'h0);
    vecs[13] = mk(3'd4, 3'd4, 32'h6000_0000, 8'hFF, 64'h0, 4'd2, 3'd1, 1'b1, 64'h0);
    vecs[14] = mk(3'd3, 3'd3, 32'h6000_0000, 8'hFF, 64'h1234, 4'd4, 3'd1, 1'b1, 64'h0);
    vecs[15] = mk(3'd7, 3'd3, 32'h6000_0000, 8'hFF, 64'h9999, 4'd0, 3'd0, 1'b1, 64'h0);
    vecs[16] = mk(3'd4, 3'd3, 32'h6000_0000, 8'hFF, 64'h0, 4'd3, 3'd1, 1'b0, 64'h0);

    for (int i = 0; i < NUM_REGS; i++) model[i] = 64'h0;

    reset = 1'b0;
    tl.a_valid = 1'b0; tl.a_opcode = 3'd0; tl.a_param = 3'd0; tl.a_size = 3'd0;
    tl.a_source = 4'd0; tl.a_address = 32'h0; tl.a_mask = 8'h0; tl.a_data = 64'h0;
    tl.d_ready = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk("rst_a_ready",  64'(tl.a_ready),  64'd1);
    chk("rst_d_valid",  64'(tl.d_valid),  64'd0);
    chk("rst_d_opcode", 64'(tl.d_opcode), 64'd0);
    chk("rst_d_size",   64'(tl.d_size),   64'd0);
    chk("rst_d_source", 64'(tl.d_source), 64'd0);
    chk("rst_d_denied", 64'(tl.d_denied), 64'd0);
    chk("rst_d_data",   tl.d_data,        64'd0);
    chk_regs("rst");

    for (int i = 0; i < NV; i++) begin
      send(vecs[i], $sformatf("vec%0d", i));
    end

    // Backpressure: response must hold and A must stay blocked.
    tl.d_ready = 1'b0;
    drive_req(mk(3'd4, 3'd3, 32'h6000_0008, 8'hFF, 64'h0, 4'd9, 3'd1, 1'b0,
                 64'h11223344556677AA), "bp");
    held_data = 64'h11223344556677AA; held_op = 3'd1; held_src = 4'd9; held_den = 1'b0;
    tl.a_valid = 1'b1; tl.a_opcode = 3'd0; tl.a_size = 3'd3;
    tl.a_address = 32'h6000_0000; tl.a_mask = 8'hFF; tl.a_data = 64'hBAD0BAD0BAD0BAD0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      chk($sformatf("bp%0d_d_valid", c),  64'(tl.d_valid),  64'd1);
      chk($sformatf("bp%0d_a_ready", c),  64'(tl.a_ready),  64'd0);
      chk($sformatf("bp%0d_d_data", c),   tl.d_data,        held_data);
      chk($sformatf("bp%0d_d_opcode", c), 64'(tl.d_opcode), 64'(held_op));
      chk($sformatf("bp%0d_d_source", c), 64'(tl.d_source), 64'(held_src));
      chk($sformatf("bp%0d_d_denied", c), 64'(tl.d_denied), 64'(held_den));
    end
    tl.a_valid = 1'b0;
    tl.d_ready = 1'b1;
    chk("bp_release_a_ready_same_cycle", 64'(tl.a_ready), 64'd0);
    @(negedge clock);
    chk("bp_release_d_valid", 64'(tl.d_valid), 64'd0);
    chk("bp_release_a_ready", 64'(tl.a_ready), 64'd1);
    chk_regs("bp");

    // Reset while a response is pending.
    tl.d_ready = 1'b0;
    drive_req(mk(3'd4, 3'd3, 32'h6000_0038, 8'hFF, 64'h0, 4'd4, 3'd1, 1'b0,
                 64'hDEADBEEF1234F00D), "rr");
    reset = 1'b0;
    @(negedge clock);
    for (int i = 0; i < NUM_REGS; i++) model[i] = 64'h0;
    chk("rr_d_valid", 64'(tl.d_valid), 64'd0);
    chk("rr_d_data",  tl.d_data,       64'd0);
    chk("rr_a_ready", 64'(tl.a_ready), 64'd1);
    chk_regs("rr");
    reset = 1'b1;
    tl.d_ready = 1'b1;
    @(negedge clock);
    chk("rr_release_a_ready", 64'(tl.a_ready), 64'd1);
    chk("rr_release_d_valid", 64'(tl.d_valid), 64'd0);
    send(mk(3'd4, 3'd3, 32'h6000_0008, 8'hFF, 64'h0, 4'd2, 3'd1, 1'b0, 64'h0), "post_rst_get");

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end

endmodule

// File: doc/mmio_tl_responder.md
Name: mmio_tl_responder

Overview:
- TileLink-UL responder (manager) that terminates the uncached/MMIO traffic issued by the data-cache IO MSHR.
- Accepts Get, PutFullData and PutPartialData on channel A. Returns AccessAckData or AccessAck on channel D from a small bank of 64-bit device registers.
- Atomics, intents, misaligned and out-of-range requests get a denied response. This gives the IO MSHR a synthesizable endpoint for directed and random MMIO testing.

Parameters:
- ADDR_W, 32, channel A address width.
- SRC_W, 4, source-ID width, echoed on D.
- NUM_REGS, 8, number of 64-bit registers; must be a power of two, at most 256.
- BASE_ADDR, 32'h6000_0000, base address; must be aligned to NUM_REGS*8.

Ports:
- clock  in  1  clock
- reset  in  1  synchronous, active-low reset
- a_valid  in  1  channel A request valid
- a_ready  out  1  channel A ready
- a_opcode  in  3  0 PutFull, 1 PutPartial, 2 Arith, 3 Logical, 4 Get, 5 Intent
- a_param  in  3  ignored
- a_size  in  3  log2 bytes
- a_source  in  SRC_W  requester ID
- a_address  in  ADDR_W  byte address
- a_mask  in  8  byte-lane enables
- a_data  in  64  write data
- d_valid  out  1  response valid
- d_ready  in  1  response ready
- d_opcode  out  3  0 AccessAck, 1 AccessAckData
- d_size  out  3  echo of a_size
- d_source  out  SRC_W  echo of a_source
- d_denied  out  1  error response
- d_data  out  64  read data
- regs_q  out  NUM_REGS*64  flattened register contents; register i sits at bits [64i+63:64i]

Behaviour:
- Interface: reset is synchronous and active-low (reset=0 resets on the clock edge); clock is clock.
- Reset values: state IDLE; d_valid=0; d_opcode, d_size, d_source, d_denied, d_data all 0; all registers 0; a_ready=1 after reset.
- FSM has two states, IDLE and RESP.
- a_ready = (state==IDLE), purely combinational from state.
- A-channel fire: a_valid & a_ready in IDLE, evaluated at a clock edge. On fire:
  - capture a_size and a_source;
  - decode the request;
  - perform any write at that edge;
  - capture read data from the pre-write register value (no write occurs on a Get anyway);
  - go to RESP.
- Response latency: d_valid=1 exactly one cycle after A fire.
- In RESP, all d_* outputs hold stable until d_valid & d_ready.
- On D fire: go to IDLE with d_valid=0. A new request can be accepted on the next cycle, so peak throughput is one transaction per 2 cycles.
- The A channel is never accepted in the same cycle as D fire.
- Decode:
  - off = a_address - BASE_ADDR;
  - idx = off[log2(NUM_REGS)+2:3];
  - in_range = (a_address >= BASE_ADDR) && (off < NUM_REGS*8);
  - aligned = (a_address & ((1<<a_size)-1)) == 0;
  - size_ok = a_size <= 3.
  - ok = in_range & aligned & size_ok.
- Get: d_opcode=1. If ok, d_data = reg[idx] (full 64-bit word; the requester selects lanes) and d_denied=0. Otherwise d_data=0 and d_denied=1.
- PutFull / PutPartial: d_opcode=0, d_data=0.
  - If ok, write byte lane b of reg[idx] = a_data[8b+7:8b] for each b where a_mask[b]=1.
  - PutFull with a mask inconsistent with size is still written per mask, with no check.
  - If not ok: no register changes and d_denied=1.
- Arith / Logical: d_opcode=1, d_data=0, d_denied=1, no write.
- Intent (5) or opcodes 6/7: d_opcode=0, d_denied=1, no write.
- Address wrap: the in-range check uses an unsigned compare, so an address below BASE_ADDR is denied; it must never alias to register NUM_REGS-1.
- Reset while in RESP: the pending response is dropped, d_valid=0 on the next cycle, and registers clear.
- regs_q is registered state, so an update is visible the cycle after the write fire.

Decomposition:
- Package tl_ul_pkg holds:
  - typedef tl_a_op_e (PutFull=0, PutPartial=1, Arith=2, Logical=3, Get=4, Intent=5);
  - typedef tl_d_op_e (AccessAck=0, AccessAckData=1);
  - a packed struct tl_d_resp_t {opcode, size, source, denied, data}.
- One sub-module, mmio_tl_regfile: the byte-masked write/read register bank with NUM_REGS entries. The FSM and decode stay in the top level.

Test Plan:
- Reset release, then PutFull at 0x6000_0008, mask 0xFF, data 0x1122334455667788 -> a_ready=1 at fire; d_valid on the next cycle with d_opcode=0, d_denied=0, and d_source echoed; regs_q register 1 = 0x1122334455667788.
- PutPartial at 0x6000_0008, size 0, mask 0x01, data 0xAA -> then Get size 3 at 0x6000_0008 returns d_opcode=1, d_data=0x11223344556677AA, d_denied=0.
- Get at 0x6000_0040 (out of range) and at 0x5FFF_FFF8 (below base) -> d_denied=1, d_data=0, registers unchanged.
- Get size 2 at 0x6000_0002 (misaligned) -> d_denied=1. Arith opcode 2 at 0x6000_0000 -> d_opcode=1, d_denied=1, register 0 unchanged.
- Backpressure: hold d_ready=0 for 5 cycles after a Get -> d_* stable, a_ready=0 throughout. On d_ready=1, D fires, and a_ready=1 the next cycle, not the same cycle.
- Assert reset=0 while in RESP -> d_valid=0 the next cycle, all regs_q=0, a_ready=1 after release.
